// File: rtl/dmem_if.sv
// Request/response bus between a requester (core fetch or load/store unit)
// and a memory responder.
//
// Handshake: a transfer happens on any rising clk edge where valid and ready
// are both high. The source holds valid and its payload steady until that edge.
// The sink may drive ready without looking at valid. Payload is don't-care
// while valid is low.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder: one outstanding request, fixed LATENCY from accept
// edge to response, byte-strobed writes and word reads on an internal array.
// The access commits on the edge that enters RESP, so accesses land in
// accept order.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag requests with
// req_addr[1:0]!=0. Such requests then write nothing and return rdata=0 and
// err=1. Without the macro the low address bits are ignored and err stays 0.
module dmem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      dbus,
  output logic [1:0] dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // WAIT preload: WAIT is held for LATENCY-1 edges, with RESP entered on the edge seeing 0.
  localparam logic [3:0] LAT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  lat_cnt;

  // Latched request
  logic          q_we;
  logic [AW+1:0] q_addr;
  logic [31:0]   q_wdata;
  logic [3:0]    q_wstrb;

  logic [31:0] mem [DEPTH_WORDS];

  // Request as seen at the commit edge. With LATENCY==1 commit coincides
  // with accept, so the live bus is used instead of the latched copy.
  logic          accept;
  logic          commit;
  logic          c_we;
  logic [AW+1:0] c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_wstrb;
  logic [AW-1:0] c_idx;
  logic          c_misaligned;
  logic [31:0]   c_rword;

  logic unused_addr_bits;

  assign accept    = (state == IDLE) && dbus.req_valid;
  assign dbg_state = state;

  // Select live or latched request and decide whether this edge commits
  always_comb begin
    if (state == IDLE) begin
      c_we    = dbus.req_we;
      c_addr  = dbus.req_addr[AW+1:0];
      c_wdata = dbus.req_wdata;
      c_wstrb = dbus.req_wstrb;
    end else begin
      c_we    = q_we;
      c_addr  = q_addr;
      c_wdata = q_wdata;
      c_wstrb = q_wstrb;
    end
    commit = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        commit = accept && (LATENCY == 1);
      end else if (state == WAIT) begin
        commit = (lat_cnt == 4'd0);
      end
    end
  end

  assign c_idx = c_addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign c_misaligned = |c_addr[1:0];
`else
  assign c_misaligned = 1'b0;
`endif

  // Writes and flagged requests return zero data
  assign c_rword = (c_we || c_misaligned) ? 32'h0 : mem[c_idx];

  // Upper address bits alias; the low two only matter with the alignment check
  assign unused_addr_bits = ^{dbus.req_addr[31:AW+2], c_addr[1:0]};

  // Array write port: enabled bytes update on the commit edge
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (c_wstrb[b]) begin
          mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      lat_cnt         <= 4'd0;
      dbus.req_ready  <= 1'b1;
      dbus.resp_valid <= 1'b0;
      dbus.resp_rdata <= 32'h0;
      dbus.resp_err   <= 1'b0;
      q_we            <= 1'b0;
      q_addr          <= '0;
      q_wdata         <= 32'h0;
      q_wstrb         <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_we           <= dbus.req_we;
            q_addr         <= dbus.req_addr[AW+1:0];
            q_wdata        <= dbus.req_wdata;
            q_wstrb        <= dbus.req_wstrb;
            dbus.req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state           <= RESP;
              dbus.resp_valid <= 1'b1;
              dbus.resp_rdata <= c_rword;
              dbus.resp_err   <= c_misaligned;
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            state           <= RESP;
            dbus.resp_valid <= 1'b1;
            dbus.resp_rdata <= c_rword;
            dbus.resp_err   <= c_misaligned;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          if (dbus.resp_ready) begin
            state           <= IDLE;
            dbus.resp_valid <= 1'b0;
            dbus.req_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
